pipe_hazard_controller: RTL
===========================

Name: pipe_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage 24-bit pipeline.
- Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers and the PC enable.
- Resolves three hazards: load-use data hazards, multi-cycle data-memory accesses, and taken branches.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- REG_BITS, 4, width of register-index fields.
- MEM_LATENCY, 2, data-memory access time in cycles. Legal range 1..16.
- CNT_BITS, 16, width of stall_count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- id_src1  in  REG_BITS  source register 1 of the instruction in ID.
- id_src1_valid  in  1  id_src1 is actually read.
- id_src2  in  REG_BITS  source register 2 of the instruction in ID.
- id_src2_valid  in  1  id_src2 is actually read.
- ex_dest  in  REG_BITS  destination register of the instruction in EX.
- ex_mem_read_enable  in  1  instruction in EX is a load.
- ex_writeback_enable  in  1  instruction in EX writes the register file.
- branch_taken  in  1  instruction in EX resolved a taken branch.
- mem_read_enable  in  1  instruction in MEM performs a data read.
- mem_write_enable  in  1  instruction in MEM performs a data write.
- pc_enable  out  1  PC update allowed.
- if_id_enable  out  1  IF/ID register load.
- if_id_flush  out  1  IF/ID loads a bubble.
- id_ex_enable  out  1  ID/EX register load.
- id_ex_flush  out  1  ID/EX loads a bubble.
- ex_mem_enable  out  1  EX/MEM register load.
- mem_wb_flush  out  1  MEM/WB loads a bubble.
- mem_busy  out  1  pipeline frozen for a memory access.
- stall_count  out  CNT_BITS  saturating count of stall cycles.

Behaviour:

State machine:
- States: RUN=0, MEM_WAIT=1. Wait counter wcnt is ceil(log2(MEM_LATENCY)) bits wide, minimum 1.
- mem_access = mem_read_enable | mem_write_enable.

Control outputs:
- All control outputs are combinational decodes of state, wcnt and the inputs. There is no added latency.
- Defaults: every enable = 1, every flush = 0, mem_busy = 0.

freeze condition:
- freeze = (state==RUN & mem_access & MEM_LATENCY>1) | (state==MEM_WAIT & wcnt!=0).
- On freeze: pc_enable, if_id_enable, id_ex_enable and ex_mem_enable are 0; mem_wb_flush=1; mem_busy=1.
- In RUN with freeze: next state MEM_WAIT, wcnt <= MEM_LATENCY-2.
- In MEM_WAIT with wcnt!=0: wcnt decrements.
- In MEM_WAIT with wcnt==0 (release cycle): no freeze, pipeline advances, access completes, next state RUN.
- The held mem_access in the release cycle must NOT retrigger a freeze.
- Total freeze cycles per access = MEM_LATENCY-1. With MEM_LATENCY=1 the FSM never leaves RUN.

Branch (only when freeze=0):
- branch_taken=1 -> if_id_flush=1, id_ex_flush=1, pc_enable=1 (PC loads the target).

Load-use (only when freeze=0 and branch_taken=0):
- Condition: ex_mem_read_enable & ex_writeback_enable & ((id_src1_valid & id_src1==ex_dest) | (id_src2_valid & id_src2==ex_dest)).
- Response: pc_enable=0, if_id_enable=0, id_ex_flush=1 for exactly one cycle. The bubble then clears the condition.

Priority and simultaneous events:
- Priority is freeze > branch > load-use.
- A branch or load-use condition present during a freeze is held stable by the frozen registers and is acted on in the release cycle.

stall_count:
- +1 on every cycle with freeze=1 or a load-use stall.
- Saturates at all-ones. Branch flush cycles are not counted.

Reset (synchronous):
- On the clock edge with rst=1: state<=RUN, wcnt<=0, stall_count<=0.
- While rst=1, outputs are forced: pc_enable=0, all register enables=0, if_id_flush=id_ex_flush=mem_wb_flush=1, mem_busy=0.
- rst asserted during MEM_WAIT aborts the wait. The first cycle after reset is RUN with default outputs.

Test Plan:
- Reset: hold rst 2 cycles, then release with all inputs 0 -> pc_enable=1, all flushes 0, stall_count=0, mem_busy=0.
- Load-use: ex_mem_read_enable=1, ex_writeback_enable=1, ex_dest=4'h5, id_src2=4'h5, id_src2_valid=1 -> one cycle of pc_enable=0, if_id_enable=0, id_ex_flush=1, stall_count=1.
  - Repeat with id_src2_valid=0 -> no stall.
- Memory wait, MEM_LATENCY=4: mem_read_enable=1 held -> freeze for exactly 3 cycles (mem_busy=1, mem_wb_flush=1), then release cycle with all enables 1, then RUN.
  - Held mem_read_enable does not retrigger. stall_count=3.
- MEM_LATENCY=1 build: mem_write_enable=1 for 5 cycles -> never frozen, state stays RUN.
- Branch during freeze, MEM_LATENCY=3: mem_access and branch_taken=1 together -> 2 freeze cycles with no flushes, then release cycle with if_id_flush=id_ex_flush=1.
- Saturation and reset abort: force stall_count to 16'hFFFF, apply a load-use stall -> stays 16'hFFFF.
  - Assert rst in the 2nd freeze cycle of MEM_LATENCY=4 -> next cycle RUN, stall_count=0.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: hazard-controller bundle of pipeline status inputs and stall/flush controls
interface pipe_hazard_if #(
  parameter int REG_BITS = 4,
  parameter int CNT_BITS = 16
);
  logic [REG_BITS-1:0] id_src1;
  logic                id_src1_valid;
  logic [REG_BITS-1:0] id_src2;
  logic                id_src2_valid;
  logic [REG_BITS-1:0] ex_dest;
  logic                ex_mem_read_enable;
  logic                ex_writeback_enable;
  logic                branch_taken;
  logic                mem_read_enable;
  logic                mem_write_enable;
  logic                pc_enable;
  logic                if_id_enable;
  logic                if_id_flush;
  logic                id_ex_enable;
  logic                id_ex_flush;
  logic                ex_mem_enable;
  logic                mem_wb_flush;
  logic                mem_busy;
  logic [CNT_BITS-1:0] stall_count;
  modport master (
    output id_src1, id_src1_valid, id_src2, id_src2_valid, ex_dest,
           ex_mem_read_enable, ex_writeback_enable, branch_taken,
           mem_read_enable, mem_write_enable,
    input  pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
           ex_mem_enable, mem_wb_flush, mem_busy, stall_count
  );
  modport slave (
    input  id_src1, id_src1_valid, id_src2, id_src2_valid, ex_dest,
           ex_mem_read_enable, ex_writeback_enable, branch_taken,
           mem_read_enable, mem_write_enable,
    output pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
           ex_mem_enable, mem_wb_flush, mem_busy, stall_count
  );
endinterface

// File: rtl/pipe_hazard_controller.sv
// pipe_hazard_controller: stall/flush sequencer for memory waits, taken branches and load-use hazards
module pipe_hazard_controller #(
  parameter int REG_BITS    = 4,
  parameter int MEM_LATENCY = 2,
  parameter int CNT_BITS    = 16
) (
  input logic         clk,
  input logic         rst,
  pipe_hazard_if.slave bus
);
  localparam int W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int INIT = (MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;
  state_t              state_q, state_d;
  logic [W-1:0]        wcnt_q, wcnt_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                mem_access, freeze, hit, load_use;
  logic [REG_BITS-1:0] dst;
  // hazard decode, next state and control outputs; the release cycle of a wait never refreezes
  always_comb begin
    dst        = bus.ex_dest;
    mem_access = bus.mem_read_enable | bus.mem_write_enable;
    freeze     = (state_q == RUN && mem_access && MEM_LATENCY > 1) || (state_q == MEM_WAIT && wcnt_q != '0);
    hit        = bus.ex_mem_read_enable && bus.ex_writeback_enable &&
                 ((bus.id_src1_valid && bus.id_src1 == dst) || (bus.id_src2_valid && bus.id_src2 == dst));
    load_use   = !freeze && !bus.branch_taken && hit;
    state_d    = freeze ? MEM_WAIT : RUN;
    wcnt_d     = freeze ? (state_q == RUN ? W'(INIT) : wcnt_q - 1'b1) : '0;
    cnt_d      = ((freeze || load_use) && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    bus.pc_enable     = !rst && !freeze && !load_use;
    bus.if_id_enable  = !rst && !freeze && !load_use;
    bus.if_id_flush   = rst || (!freeze && bus.branch_taken);
    bus.id_ex_enable  = !rst && !freeze;
    bus.id_ex_flush   = rst || (!freeze && (bus.branch_taken || load_use));
    bus.ex_mem_enable = !rst && !freeze;
    bus.mem_wb_flush  = rst || freeze;
    bus.mem_busy      = !rst && freeze;
    bus.stall_count   = cnt_q;
  end
  // state, wait counter and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
